// File: rtl/bram_r_unloader.sv
// bram_r_unloader: reads a contiguous range of result words from BRAM_R
// port B and streams them out lane by lane (lane 0 first) on a valid/ready
// interface. Read latency is absorbed by a small word FIFO whose occupancy
// (including reads still in flight) gates read issue, so it never overflows.
module bram_r_unloader #(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BRAM_DEPTH = 1024,
    parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
    parameter int RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            word_count,
    output logic                           busy,
    output logic                           done,
    output logic                           bram_en,
    output logic [ADDR_WIDTH-1:0]          bram_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_rdata,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_last
);

    localparam int FIFO_DEPTH = RD_LATENCY + 1;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W      = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam int LANE_W     = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
    localparam int WORD_W     = PE_COUNT * DATA_WIDTH;
    localparam int CNT_W      = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BRAM_DEPTH - 1);
    localparam logic [OCC_W-1:0]      OCC_LIMIT = OCC_W'(FIFO_DEPTH);
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(PE_COUNT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      rd_cnt;
    logic [CNT_W-1:0]      ld_cnt;
    logic [RD_LATENCY-1:0] vld_p;
    logic [WORD_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occ;
    logic [WORD_W-1:0]     sh_data;
    logic [LANE_W-1:0]     lane;
    logic                  last_word;
    logic                  valid_q;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  fire;
    logic                  lane_end;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    // Words held in the FIFO plus reads still travelling through the BRAM.
    always_comb begin
        occ = fifo_count;
        for (int i = 0; i < RD_LATENCY; i++) begin
            occ = occ + OCC_W'(vld_p[i]);
        end
    end

    assign issue    = (state == S_READ) && (occ < OCC_LIMIT);
    assign push     = vld_p[RD_LATENCY-1];
    assign fire     = valid_q && m_ready;
    assign lane_end = (lane == LAST_LANE);
    assign pop      = (fifo_count != '0) && (!valid_q || (fire && lane_end));

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign bram_en   = issue;
    assign bram_addr = rd_addr;
    assign m_valid   = valid_q;
    assign m_data    = sh_data[DATA_WIDTH-1:0];
    assign m_last    = valid_q && last_word && lane_end;

    // Transfer control: command latch, read issue/address walk, completion.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            count_q <= '0;
            rd_cnt  <= '0;
            rd_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count_q <= word_count;
                        rd_addr <= base_addr;
                        rd_cnt  <= '0;
                        state   <= (word_count == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        rd_addr <= addr_inc(rd_addr);
                        rd_cnt  <= rd_cnt + CNT_ONE;
                        if (rd_cnt + CNT_ONE == count_q) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The final beat leaves only once everything upstream is empty.
                    if ((fifo_count == '0) && (vld_p == '0) && fire && m_last) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // In-flight read tracking and FIFO pointers/occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + OCC_W'(1);
                2'b01:   fifo_count <= fifo_count - OCC_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Capture returned BRAM data exactly when its read matures, regardless of m_ready.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bram_rdata;
        end
    end

    // Lane serializer: load a word from the FIFO head, shift out one lane per beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q   <= 1'b0;
            sh_data   <= '0;
            lane      <= '0;
            last_word <= 1'b0;
            ld_cnt    <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                ld_cnt <= '0;
            end
            if (pop) begin
                sh_data   <= fifo_mem[rd_ptr];
                lane      <= '0;
                valid_q   <= 1'b1;
                ld_cnt    <= ld_cnt + CNT_ONE;
                last_word <= (ld_cnt + CNT_ONE == count_q);
            end else if (fire) begin
                if (lane_end) begin
                    valid_q <= 1'b0;
                end else begin
                    sh_data <= sh_data >> DATA_WIDTH;
                    lane    <= lane + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_r_unloader.sv
// Testbench for bram_r_unloader: two instances (RD_LATENCY 1 and 2) share
// the same command and m_ready stimulus, each with its own BRAM_R model that
// returns word[a] lanes = {a*4+3, a*4+2, a*4+1, a*4} and junk at any cycle
// other than exactly RD_LATENCY after a read. Beats are checked against an
// arithmetic reference of the expected stream.
module tb_bram_r_unloader;

    localparam int MAXB = 4200;
    localparam int MAXA = 1100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        m_ready;

    logic         dut_busy    [2];
    logic         dut_done    [2];
    logic         dut_en      [2];
    logic [9:0]   dut_addr    [2];
    logic [127:0] dut_rdata   [2];
    logic         dut_valid   [2];
    logic [31:0]  dut_data    [2];
    logic         dut_last    [2];

    int checks   = 0;
    int failures = 0;

    // Observation records filled by collect()
    int          got_n     [2];
    logic [31:0] got_data  [2][0:MAXB-1];
    logic        got_last  [2][0:MAXB-1];
    int          got_iter  [2][0:MAXB-1];
    int          addr_n    [2];
    logic [9:0]  got_addr  [2][0:MAXA-1];
    int          stall_bad [2];
    int          done_n    [2];
    int          done_iter [2];
    int          busy_n    [2];
    int          first_v   [2];
    int          bubbles   [2];
    int          rst_bad   [2];

    logic [127:0] junk;

    always #5 clk = ~clk;

    always @(posedge clk) junk <= {$urandom, $urandom, $urandom, $urandom};

    function automatic logic [127:0] word_of(input logic [9:0] a);
        logic [127:0] w;
        for (int j = 0; j < 4; j++) w[j*32 +: 32] = {22'd0, a} * 32'd4 + 32'(j);
        return w;
    endfunction

    // Reference: k-th beat of a transfer starting at word address base
    function automatic logic [31:0] exp_beat(input int base, input int k);
        int a;
        a = (base + k / 4) % 1024;
        return 32'(a * 4 + k % 4);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [127:0] pipe [2];
        logic         pv   [2];

        bram_r_unloader #(.RD_LATENCY(g + 1)) u_dut (
            .clk        (clk),
            .rstn       (rstn),
            .start      (start),
            .base_addr  (base_addr),
            .word_count (word_count),
            .busy       (dut_busy[g]),
            .done       (dut_done[g]),
            .bram_en    (dut_en[g]),
            .bram_addr  (dut_addr[g]),
            .bram_rdata (dut_rdata[g]),
            .m_valid    (dut_valid[g]),
            .m_ready    (m_ready),
            .m_data     (dut_data[g]),
            .m_last     (dut_last[g])
        );

        always @(posedge clk) begin
            pv[0]   <= dut_en[g];
            pipe[0] <= word_of(dut_addr[g]);
            pv[1]   <= pv[0];
            pipe[1] <= pipe[0];
        end

        assign dut_rdata[g] = (pv[g] === 1'b1) ? pipe[g] : junk;
    end

    // Drives start (iteration 0 and optionally restart_at), random m_ready,
    // an optional reset after rst_at beats of instance 0, and records what
    // both instances do. Sampling happens 1 time unit after the falling edge.
    task automatic collect(input int total, input int pct, input int max_cyc,
                           input int restart_at, input logic [9:0] rbase, input int rst_at);
        logic        pstall [2];
        logic [31:0] pdata  [2];
        logic        plast  [2];
        int rph;
        int post;
        int tail;
        bit zchk;
        rph = 0; post = 0; tail = 0;
        for (int d = 0; d < 2; d++) begin
            got_n[d] = 0; addr_n[d] = 0; stall_bad[d] = 0; done_n[d] = 0;
            done_iter[d] = -1; busy_n[d] = 0; first_v[d] = -1; bubbles[d] = 0;
            rst_bad[d] = 0; pstall[d] = 1'b0; pdata[d] = '0; plast[d] = 1'b0;
        end
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            zchk = 1'b0;
            start = (i == 0) || (i == restart_at);
            if (i == restart_at) base_addr = rbase;
            if (rph == 1) begin
                rstn = 1'b1; rph = 2; zchk = 1'b1;
            end else if (rph == 0 && rst_at > 0 && got_n[0] >= rst_at) begin
                rstn = 1'b0; rph = 1;
            end
            m_ready = (rph == 1) ? 1'b0 : ($urandom_range(99) < pct);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (zchk) begin
                    if (dut_busy[d] || dut_done[d] || dut_en[d] || dut_valid[d] || dut_last[d]
                        || dut_addr[d] != 10'd0 || dut_data[d] != 32'd0) rst_bad[d]++;
                end else if (pstall[d]) begin
                    if (!dut_valid[d] || dut_data[d] !== pdata[d] || dut_last[d] !== plast[d])
                        stall_bad[d]++;
                end
                if (dut_valid[d] && first_v[d] < 0) first_v[d] = i;
                if (dut_busy[d]) busy_n[d]++;
                if (dut_done[d]) begin done_n[d]++; done_iter[d] = i; end
                if (dut_en[d] && addr_n[d] < MAXA) begin
                    got_addr[d][addr_n[d]] = dut_addr[d];
                    addr_n[d]++;
                end
                if (!dut_valid[d] && got_n[d] > 0 && got_n[d] < total) bubbles[d]++;
                if (dut_valid[d] && m_ready && got_n[d] < MAXB) begin
                    got_data[d][got_n[d]] = dut_data[d];
                    got_last[d][got_n[d]] = dut_last[d];
                    got_iter[d][got_n[d]] = i;
                    got_n[d]++;
                end
                pstall[d] = dut_valid[d] && !m_ready;
                pdata[d]  = dut_data[d];
                plast[d]  = dut_last[d];
            end
            if (rph == 2) begin
                post++;
                if (post >= 10) break;
            end else if (rst_at <= 0 && done_n[0] > 0 && done_n[1] > 0) begin
                tail++;
                if (tail > 3) break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; m_ready = 1'b0; base_addr = '0; word_count = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({dut_busy[d], dut_done[d], dut_en[d], dut_valid[d], dut_last[d]} !== 5'b0
                || dut_addr[d] !== 10'd0 || dut_data[d] !== 32'd0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: busy=%b done=%b en=%b addr=%0d valid=%b data=%h last=%b, want all 0",
                         d, dut_busy[d], dut_done[d], dut_en[d], dut_addr[d], dut_valid[d], dut_data[d], dut_last[d]);
            end
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        base_addr = 10'd0; word_count = 11'd3;
        collect(12, 100, 200, -1, 10'd0, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n[d] !== 12) begin
                failures++; $display("FAIL basic_count dut%0d: got %0d beats, want 12", d, got_n[d]);
            end
            for (int k = 0; k < got_n[d] && k < 12; k++) begin
                checks++;
                if (got_data[d][k] !== 32'(k) || got_last[d][k] !== (k == 11)) begin
                    failures++;
                    $display("FAIL basic_beat dut%0d k=%0d: data=%0d last=%b, want data=%0d last=%b",
                             d, k, got_data[d][k], got_last[d][k], k, (k == 11));
                    break;
                end
            end
            checks++;
            if (done_n[d] !== 1 || got_n[d] < 12 || done_iter[d] !== got_iter[d][11] + 1) begin
                failures++;
                $display("FAIL basic_done dut%0d: done_n=%0d done_iter=%0d, want 1 pulse right after last beat",
                         d, done_n[d], done_iter[d]);
            end
            checks++;
            if (bubbles[d] !== 0) begin
                failures++; $display("FAIL basic_bubbles dut%0d: %0d bubbles, want 0", d, bubbles[d]);
            end
            checks++;
            if (first_v[d] < 0 || first_v[d] > d + 1 + 4) begin
                failures++;
                $display("FAIL basic_latency dut%0d: first valid at iter %0d, want <= %0d", d, first_v[d], d + 5);
            end
        end
    endtask

    task automatic test_wrap();
        base_addr = 10'd1022; word_count = 11'd4;
        collect(16, 100, 200, -1, 10'd0, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (addr_n[d] !== 4) begin
                failures++; $display("FAIL wrap_reads dut%0d: %0d reads, want 4", d, addr_n[d]);
            end
            for (int k = 0; k < addr_n[d] && k < 4; k++) begin
                checks++;
                if (got_addr[d][k] !== 10'((1022 + k) % 1024)) begin
                    failures++;
                    $display("FAIL wrap_addr dut%0d k=%0d: addr=%0d, want %0d", d, k, got_addr[d][k], (1022 + k) % 1024);
                    break;
                end
            end
            checks++;
            if (got_n[d] !== 16) begin
                failures++; $display("FAIL wrap_count dut%0d: got %0d beats, want 16", d, got_n[d]);
            end
            for (int k = 0; k < got_n[d] && k < 16; k++) begin
                checks++;
                if (got_data[d][k] !== exp_beat(1022, k) || got_last[d][k] !== (k == 15)) begin
                    failures++;
                    $display("FAIL wrap_beat dut%0d k=%0d: data=%0d, want %0d", d, k, got_data[d][k], exp_beat(1022, k));
                    break;
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int b;
        b = int'($urandom_range(1023));
        base_addr = 10'(b); word_count = 11'd5;
        collect(20, 30, 1000, -1, 10'd0, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n[d] !== 20 || done_n[d] !== 1) begin
                failures++;
                $display("FAIL bp_count dut%0d: beats=%0d done_n=%0d, want 20 and 1", d, got_n[d], done_n[d]);
            end
            for (int k = 0; k < got_n[d] && k < 20; k++) begin
                checks++;
                if (got_data[d][k] !== exp_beat(b, k) || got_last[d][k] !== (k == 19)) begin
                    failures++;
                    $display("FAIL bp_beat dut%0d k=%0d: data=%0d last=%b, want %0d", d, k, got_data[d][k], got_last[d][k], exp_beat(b, k));
                    break;
                end
            end
            checks++;
            if (stall_bad[d] !== 0) begin
                failures++; $display("FAIL bp_stable dut%0d: %0d unstable stalled cycles, want 0", d, stall_bad[d]);
            end
        end
    endtask

    task automatic test_zero_length();
        base_addr = 10'd7; word_count = 11'd0;
        collect(0, 100, 50, -1, 10'd0, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy_n[d] !== 1 || done_n[d] !== 1 || done_iter[d] !== 1) begin
                failures++;
                $display("FAIL zero_len_ctrl dut%0d: busy_cycles=%0d done_n=%0d done_iter=%0d, want 1 1 1",
                         d, busy_n[d], done_n[d], done_iter[d]);
            end
            checks++;
            if (addr_n[d] !== 0 || first_v[d] !== -1) begin
                failures++;
                $display("FAIL zero_len_quiet dut%0d: reads=%0d first_valid=%0d, want 0 and none", d, addr_n[d], first_v[d]);
            end
        end
    endtask

    task automatic test_start_busy();
        base_addr = 10'd100; word_count = 11'd3;
        collect(12, 100, 200, 5, 10'd200, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n[d] !== 12 || addr_n[d] !== 3 || done_n[d] !== 1) begin
                failures++;
                $display("FAIL busy_start_count dut%0d: beats=%0d reads=%0d done_n=%0d, want 12 3 1",
                         d, got_n[d], addr_n[d], done_n[d]);
            end
            for (int k = 0; k < got_n[d] && k < 12; k++) begin
                checks++;
                if (got_data[d][k] !== exp_beat(100, k)) begin
                    failures++;
                    $display("FAIL busy_start_beat dut%0d k=%0d: data=%0d, want %0d", d, k, got_data[d][k], exp_beat(100, k));
                    break;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        base_addr = 10'd50; word_count = 11'd4;
        collect(16, 100, 300, -1, 10'd0, 6);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rst_bad[d] !== 0 || done_n[d] !== 0) begin
                failures++;
                $display("FAIL reset_mid dut%0d: nonzero_after_reset=%0d done_n=%0d, want 0 and 0", d, rst_bad[d], done_n[d]);
            end
            checks++;
            if ((d == 0 && got_n[d] !== 6) || got_n[d] > 6) begin
                failures++; $display("FAIL reset_mid_beats dut%0d: got %0d beats before reset, want %0d", d, got_n[d], (d == 0) ? 6 : 5);
            end
            for (int k = 0; k < got_n[d] && k < 6; k++) begin
                checks++;
                if (got_data[d][k] !== exp_beat(50, k)) begin
                    failures++;
                    $display("FAIL reset_mid_beat dut%0d k=%0d: data=%0d, want %0d", d, k, got_data[d][k], exp_beat(50, k));
                    break;
                end
            end
        end
        base_addr = 10'd10; word_count = 11'd1;
        collect(4, 100, 200, -1, 10'd0, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n[d] !== 4 || done_n[d] !== 1) begin
                failures++;
                $display("FAIL after_reset_count dut%0d: beats=%0d done_n=%0d, want 4 and 1", d, got_n[d], done_n[d]);
            end
            for (int k = 0; k < got_n[d] && k < 4; k++) begin
                checks++;
                if (got_data[d][k] !== 32'(40 + k) || got_last[d][k] !== (k == 3)) begin
                    failures++;
                    $display("FAIL after_reset_beat dut%0d k=%0d: data=%0d, want %0d", d, k, got_data[d][k], 40 + k);
                    break;
                end
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int b;
            int n;
            int pct;
            b   = int'($urandom_range(1023));
            n   = int'($urandom_range(6, 1));
            pct = int'($urandom_range(100, 20));
            base_addr = 10'(b); word_count = 11'(n);
            collect(n * 4, pct, 1000, -1, 10'd0, 0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got_n[d] !== n * 4 || done_n[d] !== 1 || stall_bad[d] !== 0) begin
                    failures++;
                    $display("FAIL random_xfer t=%0d dut%0d: beats=%0d done_n=%0d unstable=%0d, want %0d 1 0",
                             t, d, got_n[d], done_n[d], stall_bad[d], n * 4);
                end
                for (int k = 0; k < got_n[d] && k < n * 4; k++) begin
                    checks++;
                    if (got_data[d][k] !== exp_beat(b, k) || got_last[d][k] !== (k == n * 4 - 1)) begin
                        failures++;
                        $display("FAIL random_beat t=%0d dut%0d k=%0d: data=%0d, want %0d", t, d, k, got_data[d][k], exp_beat(b, k));
                        break;
                    end
                end
            end
        end
    endtask

    task automatic test_full_depth();
        base_addr = 10'd700; word_count = 11'd1024;
        collect(4096, 100, 4400, -1, 10'd0, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n[d] !== 4096 || addr_n[d] !== 1024 || done_n[d] !== 1 || bubbles[d] !== 0) begin
                failures++;
                $display("FAIL full_depth dut%0d: beats=%0d reads=%0d done_n=%0d bubbles=%0d, want 4096 1024 1 0",
                         d, got_n[d], addr_n[d], done_n[d], bubbles[d]);
            end
            for (int k = 0; k < got_n[d] && k < 4096; k++) begin
                checks++;
                if (got_data[d][k] !== exp_beat(700, k) || got_last[d][k] !== (k == 4095)) begin
                    failures++;
                    $display("FAIL full_depth_beat dut%0d k=%0d: data=%0d, want %0d", d, k, got_data[d][k], exp_beat(700, k));
                    break;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_start_busy();
        test_reset_mid();
        test_random();
        test_full_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
